// File: rtl/exec_arbiter.sv
// exec_arbiter: shares one exec unit between the execute stage (req0) and the
// address/aux sequencer (req1). One grant per cycle at most; the result and
// flags are registered and returned one cycle later. Also holds the Z/N/C
// condition-code register, written only by grants that ask for it.
module exec_arbiter #(
  parameter int WIDTH     = 16,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_func,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_setf,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_func,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_setf,
  output logic             exu_skip,
  output logic [2:0]       exu_func,
  output logic [WIDTH-1:0] exu_a,
  output logic [WIDTH-1:0] exu_b,
  input  logic [WIDTH-1:0] exu_r,
  input  logic             exu_z,
  input  logic             exu_n,
  input  logic             exu_c,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_c,
  output logic             ccr_z,
  output logic             ccr_n,
  output logic             ccr_c
);

  // ptr_q names the requester preferred when both are valid (round-robin).
  logic             ptr_q, ptr_d;
  logic             rsp0_q, rsp0_d;
  logic             rsp1_q, rsp1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       flg_q, flg_d;
  logic [2:0]       ccr_q, ccr_d;
  logic             gnt0, gnt1;

  // Grant selection: nothing under reset or hold, lone requester always wins,
  // contention resolved by fixed priority or by the round-robin pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && !req1_valid) begin
        gnt0 = 1'b1;
      end else if (!req0_valid && req1_valid) begin
        gnt1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
        if ((PRIO_MODE == 1) || !ptr_q) gnt0 = 1'b1;
        else                            gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Steer the granted operation into the exec unit; idle cycles drive zeros
  // with skip so the unit's flags are also zero.
  always_comb begin
    exu_skip = 1'b1;
    exu_func = 3'd0;
    exu_a    = '0;
    exu_b    = '0;
    if (gnt0) begin
      exu_skip = 1'b0;
      exu_func = req0_func;
      exu_a    = req0_a;
      exu_b    = req0_b;
    end else if (gnt1) begin
      exu_skip = 1'b0;
      exu_func = req1_func;
      exu_a    = req1_a;
      exu_b    = req1_b;
    end
  end

  // Next-state: pointer flips away from the winner, response captures the
  // exec output of the grant cycle, CCR follows only setf grants.
  always_comb begin
    ptr_d  = ptr_q;
    rsp0_d = gnt0;
    rsp1_d = gnt1;
    res_d  = res_q;
    flg_d  = flg_q;
    ccr_d  = ccr_q;
    if (gnt0) ptr_d = 1'b1;
    if (gnt1) ptr_d = 1'b0;
    if (gnt0 || gnt1) begin
      res_d = exu_r;
      flg_d = {exu_z, exu_n, exu_c};
    end
    if ((gnt0 && req0_setf) || (gnt1 && req1_setf)) begin
      ccr_d = {exu_z, exu_n, exu_c};
    end
  end

  // State register; reset clears pointer, responses and CCR, dropping any
  // grant that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      res_q  <= '0;
      flg_q  <= 3'd0;
      ccr_q  <= 3'd0;
    end else begin
      ptr_q  <= ptr_d;
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
      res_q  <= res_d;
      flg_q  <= flg_d;
      ccr_q  <= ccr_d;
    end
  end

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_r      = res_q;
  assign {rsp_z, rsp_n, rsp_c} = flg_q;
  assign {ccr_z, ccr_n, ccr_c} = ccr_q;

endmodule
